mmio_uart_ctrl: RTL and testbench

Memory-mapped I/O controller for the Riscv151 core, decoding the 0x8000_00xx MMIO window that the execute stage drives. It sequences the UART receiver and transmitter: it buffers received bytes in an RX FIFO, holds one outgoing TX byte, and runs cycle and retired-instruction counters. Read data is registered so it lines up with the EX/WB pipeline register and is consumed in write-back.

---
 rtl/mmio_uart_ctrl_if.sv | 16 +
 rtl/mmio_uart_ctrl.sv | 131 +++++++++++++
 tb/tb_mmio_uart_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_ctrl_if.sv
// MMIO request bus between the EX stage (master) and the MMIO controller (slave).
//   req_valid : access this cycle
//   req_we    : 1 = store, 0 = load
//   req_addr  : byte offset within the MMIO window
//   req_wdata : store data
//   rdata     : registered load data, valid the cycle after a load
interface mmio_uart_ctrl_if;
   logic        req_valid;
   logic        req_we;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic [31:0] rdata;

   modport master (output req_valid, req_we, req_addr, req_wdata, input rdata);
   modport slave  (input req_valid, req_we, req_addr, req_wdata, output rdata);
endinterface

// File: rtl/mmio_uart_ctrl.sv
// MMIO controller: RX byte FIFO, TX holding register, cycle/instret counters.
//   clk, rst        : core clock, asynchronous active-low reset
//   bus             : MMIO request bus (slave side)
//   inst_retire     : one pulse per retired instruction
//   uart_rx_*       : byte stream from the UART receiver (ready = FIFO not full)
//   uart_tx_*       : byte stream to the UART transmitter (valid = holding reg full)
module mmio_uart_ctrl #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   mmio_uart_ctrl_if.slave      bus,
   input  logic                 inst_retire,
   input  logic [7:0]           uart_rx_data,
   input  logic                 uart_rx_valid,
   output logic                 uart_rx_ready,
   output logic [7:0]           uart_tx_data,
   output logic                 uart_tx_valid,
   input  logic                 uart_tx_ready
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned FCNT_W = PTR_W + 1;

   localparam logic [7:0] ADDR_STATUS  = 8'h00;
   localparam logic [7:0] ADDR_RX      = 8'h04;
   localparam logic [7:0] ADDR_TX      = 8'h08;
   localparam logic [7:0] ADDR_CYCLE   = 8'h10;
   localparam logic [7:0] ADDR_INSTRET = 8'h14;
   localparam logic [7:0] ADDR_CLR     = 8'h18;

   logic [7:0]           fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     rd_ptr, wr_ptr;
   logic [FCNT_W-1:0]    fifo_count;
   logic [CNT_WIDTH-1:0] cycle_cnt, instret_cnt;
   logic                 tx_drop;

   logic        rd_hit, wr_hit;
   logic        rx_nonempty, push, pop;
   logic        tx_free, tx_wr, tx_load, drop_clr, cnt_clr;
   logic [31:0] rd_mux;
   logic        unused_wdata;

   // Access decode; everything below acts on the request-cycle edge.
   assign rd_hit      = bus.req_valid && !bus.req_we;
   assign wr_hit      = bus.req_valid &&  bus.req_we;
   assign rx_nonempty = (fifo_count != '0);
   assign uart_rx_ready = (fifo_count != FCNT_W'(FIFO_DEPTH));
   assign push        = uart_rx_valid && uart_rx_ready;
   assign pop         = rd_hit && (bus.req_addr == ADDR_RX) && rx_nonempty;
   assign tx_free     = !uart_tx_valid || uart_tx_ready;
   assign tx_wr       = wr_hit && (bus.req_addr == ADDR_TX);
   assign tx_load     = tx_wr && tx_free;
   assign drop_clr    = wr_hit && (bus.req_addr == ADDR_STATUS) && bus.req_wdata[9];
   assign cnt_clr     = wr_hit && (bus.req_addr == ADDR_CLR);
   assign unused_wdata = ^{bus.req_wdata[31:10], bus.req_wdata[8]};

   // Load data mux, built from pre-update state.
   always_comb begin
      rd_mux = '0;
      case (bus.req_addr)
         ADDR_STATUS:  rd_mux = {22'b0, tx_drop, 7'(fifo_count), tx_free, rx_nonempty};
         ADDR_RX:      rd_mux = {24'b0, rx_nonempty ? fifo_mem[rd_ptr] : 8'h00};
         ADDR_CYCLE:   rd_mux = 32'(cycle_cnt);
         ADDR_INSTRET: rd_mux = 32'(instret_cnt);
         default:      rd_mux = '0;
      endcase
   end

   // Registered read data; holds on idle cycles and stores.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        bus.rdata <= '0;
      else if (rd_hit) bus.rdata <= rd_mux;
   end

   // FIFO storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= uart_rx_data;
   end

   // FIFO pointers and occupancy; power-of-two depth wraps naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
            2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // TX holding register; a load in the handshake cycle refills it directly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         uart_tx_valid <= 1'b0;
         uart_tx_data  <= '0;
         tx_drop       <= 1'b0;
      end else begin
         if (tx_load) begin
            uart_tx_data  <= bus.req_wdata[7:0];
            uart_tx_valid <= 1'b1;
         end else if (uart_tx_ready) begin
            uart_tx_valid <= 1'b0;
         end
         if (tx_wr && !tx_free) tx_drop <= 1'b1;
         else if (drop_clr)     tx_drop <= 1'b0;
      end
   end

   // Free-running counters; clear has priority over increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else if (cnt_clr) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
         if (inst_retire) instret_cnt <= instret_cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
module tb_mmio_uart_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       inst_retire;
   logic [7:0] uart_rx_data;
   logic       uart_rx_valid;
   logic       uart_rx_ready;
   logic [7:0] uart_tx_data;
   logic       uart_tx_valid;
   logic       uart_tx_ready;

   int n_tests = 0;
   int n_fail  = 0;

   mmio_uart_ctrl_if bus ();

   mmio_uart_ctrl #(.FIFO_DEPTH(8), .CNT_WIDTH(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .inst_retire   (inst_retire),
      .uart_rx_data  (uart_rx_data),
      .uart_rx_valid (uart_rx_valid),
      .uart_rx_ready (uart_rx_ready),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_valid (uart_tx_valid),
      .uart_tx_ready (uart_tx_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        req_valid;
      logic        req_we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic        rx_valid;
      logic [7:0]  rx_data;
      logic        tx_ready;
      logic [31:0] exp_rdata;
      logic        exp_rx_ready;
      logic        exp_tx_valid;
      logic [7:0]  exp_tx_data;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic rd_chk(input logic [7:0] addr, input logic [31:0] exp, input string name);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = addr;
      step();
      bus.req_valid = 1'b0;
      check(name, bus.rdata, exp);
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] data);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = addr;
      bus.req_wdata = data;
      step();
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
   endtask

   initial begin
      // One row per cycle; expectations are the outputs after that cycle's edge.
      //           v    we   addr   wdata         rxv  rxd    txr  rdata         rxr  txv  txd
      vecs[0]  = '{1'b0,1'b0,8'h00,32'h0,        1'b1,8'h41,1'b0,32'h0,        1'b1,1'b0,8'h00};
      vecs[1]  = '{1'b0,1'b0,8'h00,32'h0,        1'b1,8'h42,1'b0,32'h0,        1'b1,1'b0,8'h00};
      vecs[2]  = '{1'b1,1'b0,8'h00,32'h0,        1'b1,8'h43,1'b0,32'h0000_000B,1'b1,1'b0,8'h00};
      vecs[3]  = '{1'b1,1'b0,8'h04,32'h0,        1'b0,8'h00,1'b0,32'h0000_0041,1'b1,1'b0,8'h00};
      vecs[4]  = '{1'b1,1'b0,8'h04,32'h0,        1'b0,8'h00,1'b0,32'h0000_0042,1'b1,1'b0,8'h00};
      vecs[5]  = '{1'b1,1'b0,8'h04,32'h0,        1'b0,8'h00,1'b0,32'h0000_0043,1'b1,1'b0,8'h00};
      vecs[6]  = '{1'b1,1'b0,8'h04,32'h0,        1'b0,8'h00,1'b0,32'h0,        1'b1,1'b0,8'h00};
      vecs[7]  = '{1'b1,1'b0,8'h00,32'h0,        1'b0,8'h00,1'b0,32'h0000_0002,1'b1,1'b0,8'h00};
      vecs[8]  = '{1'b1,1'b0,8'h08,32'h0,        1'b0,8'h00,1'b0,32'h0,        1'b1,1'b0,8'h00};
      vecs[9]  = '{1'b1,1'b0,8'h00,32'h0,        1'b0,8'h00,1'b0,32'h0000_0002,1'b1,1'b0,8'h00};
      vecs[10] = '{1'b1,1'b0,8'h20,32'h0,        1'b0,8'h00,1'b0,32'h0,        1'b1,1'b0,8'h00};
      vecs[11] = '{1'b1,1'b0,8'h00,32'h0,        1'b0,8'h00,1'b0,32'h0000_0002,1'b1,1'b0,8'h00};
      vecs[12] = '{1'b1,1'b1,8'h14,32'h1234,     1'b0,8'h00,1'b0,32'h0000_0002,1'b1,1'b0,8'h00};
      vecs[13] = '{1'b1,1'b1,8'h08,32'h77,       1'b0,8'h00,1'b0,32'h0000_0002,1'b1,1'b1,8'h77};
      vecs[14] = '{1'b0,1'b0,8'h00,32'h0,        1'b0,8'h00,1'b1,32'h0000_0002,1'b1,1'b0,8'h77};
      vecs[15] = '{1'b1,1'b0,8'h04,32'h0,        1'b1,8'h99,1'b0,32'h0,        1'b1,1'b0,8'h77};
      vecs[16] = '{1'b1,1'b0,8'h04,32'h0,        1'b1,8'h5A,1'b0,32'h0000_0099,1'b1,1'b0,8'h77};
      vecs[17] = '{1'b1,1'b0,8'h04,32'h0,        1'b0,8'h00,1'b0,32'h0000_005A,1'b1,1'b0,8'h77};
      vecs[18] = '{1'b1,1'b0,8'h00,32'h0,        1'b0,8'h00,1'b0,32'h0000_0002,1'b1,1'b0,8'h77};

      rst = 1'b0;
      inst_retire   = 1'b0;
      uart_rx_data  = 8'h00;
      uart_rx_valid = 1'b0;
      uart_tx_ready = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = 8'h00;
      bus.req_wdata = 32'h0;

      // Reset values.
      repeat (2) step();
      check("rst.rdata",    bus.rdata,      32'h0);
      check("rst.rx_ready", 32'(uart_rx_ready), 32'h1);
      check("rst.tx_valid", 32'(uart_tx_valid), 32'h0);
      check("rst.tx_data",  32'(uart_tx_data),  32'h0);
      rst = 1'b1;

      // Idle 5 cycles, then counters.
      repeat (5) step();
      check("idle.rx_ready", 32'(uart_rx_ready), 32'h1);
      check("idle.tx_valid", 32'(uart_tx_valid), 32'h0);
      rd_chk(8'h10, 32'd5, "idle.cycle");
      rd_chk(8'h14, 32'd0, "idle.instret");

      // Register map and FIFO order table.
      for (int i = 0; i < NV; i++) begin
         bus.req_valid = vecs[i].req_valid;
         bus.req_we    = vecs[i].req_we;
         bus.req_addr  = vecs[i].addr;
         bus.req_wdata = vecs[i].wdata;
         uart_rx_valid = vecs[i].rx_valid;
         uart_rx_data  = vecs[i].rx_data;
         uart_tx_ready = vecs[i].tx_ready;
         step();
         check($sformatf("v%0d.rdata", i),    bus.rdata,                 vecs[i].exp_rdata);
         check($sformatf("v%0d.rx_ready", i), 32'(uart_rx_ready),        32'(vecs[i].exp_rx_ready));
         check($sformatf("v%0d.tx_valid", i), 32'(uart_tx_valid),        32'(vecs[i].exp_tx_valid));
         check($sformatf("v%0d.tx_data", i),  32'(uart_tx_data),         32'(vecs[i].exp_tx_data));
      end
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      uart_rx_valid = 1'b0;
      uart_tx_ready = 1'b0;

      // Fill past capacity: ninth byte waits at the receiver.
      for (int i = 0; i < 8; i++) begin
         uart_rx_valid = 1'b1;
         uart_rx_data  = 8'(8'h10 + i);
         step();
      end
      check("full.rx_ready", 32'(uart_rx_ready), 32'h0);
      uart_rx_data = 8'h18;
      repeat (2) step();
      check("full.held", 32'(uart_rx_ready), 32'h0);
      rd_chk(8'h00, 32'h0000_0023, "full.status");
      rd_chk(8'h04, 32'h0000_0010, "full.pop");
      check("full.reready", 32'(uart_rx_ready), 32'h1);
      step();
      check("full.refill", 32'(uart_rx_ready), 32'h0);
      uart_rx_valid = 1'b0;
      for (int i = 0; i < 8; i++)
         rd_chk(8'h04, 32'(8'h11 + i), $sformatf("drain%0d", i));
      rd_chk(8'h00, 32'h0000_0002, "drain.status");

      // TX drop when the holding register is busy.
      uart_tx_ready = 1'b0;
      wr(8'h08, 32'h55);
      wr(8'h08, 32'hAA);
      check("drop.tx_data",  32'(uart_tx_data),  32'h55);
      check("drop.tx_valid", 32'(uart_tx_valid), 32'h1);
      rd_chk(8'h00, 32'h0000_0200, "drop.status");
      wr(8'h00, 32'h200);
      rd_chk(8'h00, 32'h0000_0000, "drop.cleared");

      // Handshake and new write in the same cycle.
      uart_tx_ready = 1'b1;
      wr(8'h08, 32'h66);
      uart_tx_ready = 1'b0;
      check("hs.tx_data",  32'(uart_tx_data),  32'h66);
      check("hs.tx_valid", 32'(uart_tx_valid), 32'h1);
      rd_chk(8'h00, 32'h0000_0000, "hs.no_drop");
      uart_tx_ready = 1'b1;
      step();
      check("hs.drain", 32'(uart_tx_valid), 32'h0);
      uart_tx_ready = 1'b0;

      // Cycle counter wrap.
      force dut.cycle_cnt = 32'hFFFF_FFFE;
      step();
      release dut.cycle_cnt;
      rd_chk(8'h10, 32'hFFFF_FFFE, "wrap.fe");
      rd_chk(8'h10, 32'hFFFF_FFFF, "wrap.ff");
      rd_chk(8'h10, 32'h0000_0000, "wrap.zero");

      // Instret, and clear beating a coincident retire.
      inst_retire = 1'b1;
      repeat (3) step();
      inst_retire = 1'b0;
      rd_chk(8'h14, 32'd3, "instret.3");
      inst_retire = 1'b1;
      wr(8'h18, 32'h0);
      inst_retire = 1'b0;
      rd_chk(8'h14, 32'd0, "clr.instret");
      rd_chk(8'h10, 32'd1, "clr.cycle");

      // Asynchronous reset mid-transfer.
      uart_rx_valid = 1'b1;
      uart_rx_data  = 8'h33;
      step();
      uart_rx_valid = 1'b0;
      wr(8'h08, 32'h44);
      rd_chk(8'h00, 32'h0000_0005, "mid.status");
      #3 rst = 1'b0;
      #1;
      check("mid.rdata",    bus.rdata,          32'h0);
      check("mid.tx_valid", 32'(uart_tx_valid), 32'h0);
      check("mid.tx_data",  32'(uart_tx_data),  32'h0);
      check("mid.rx_ready", 32'(uart_rx_ready), 32'h1);
      step();
      rst = 1'b1;
      rd_chk(8'h00, 32'h0000_0002, "mid.status2");
      rd_chk(8'h04, 32'h0000_0000, "mid.rx_empty");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
